pc_phase_sequencer: RTL and testbench
=====================================

# pc_phase_sequencer

Front-end sequencer of the 4-bit processor. Holds the 12-bit program counter that addresses the 4096 x 8 program ROM. Runs the two-phase fetch/execute toggle that tells the fetch register (instruction/operand split) when to latch the ROM byte. Applies branch loads from the decode/control stage. Sits directly upstream of the fetch register and downstream of decode, for the jump-target and halt inputs.

## Interface
- RESET_PC, 12'h000: PC value after reset.
- CLK  input  1  rising-edge clock, sole clock.
- RESET  input  1  synchronous, active-high; sampled on the CLK rising edge.
- EN  input  1  run enable; 0 freezes all state.
- LOAD_PC  input  1  branch request from decode; honored only in EXECUTE.
- LOAD_ADDR  input  12  branch target.
- HALT_REQ  input  1  stop request from decode; honored only in EXECUTE.
- PC  output  12  ROM address (registered).
- PHASE  output  1  0 = FETCH, 1 = EXECUTE (registered).
- FETCH_EN  output  1  enable for the fetch register; combinational: EN & state==FETCH.
- EXEC_EN  output  1  enable for decode/ALU/accumulator; combinational: EN & state==EXECUTE.
- HALTED  output  1  high while in HALT (registered state decode).

## Operation
- States: FETCH, EXECUTE, HALT. PHASE = (state==EXECUTE).
- Reset (RESET=1 at the edge, any state, EN ignored):
  - state=FETCH, PC=RESET_PC.
  - Outputs: PHASE=0, HALTED=0. FETCH_EN=EN and EXEC_EN=0 in the following cycle.
- EN=0: state and PC hold. FETCH_EN=EXEC_EN=0.
- FETCH with EN=1:
  - Fetch register latches ROM[PC] at this edge.
  - PC <= PC+1, wrapping 12'hFFF -> 12'h000 with no flag.
  - state <= EXECUTE.
  - LOAD_PC and HALT_REQ are ignored.
- EXECUTE with EN=1:
  - LOAD_PC=1: PC <= LOAD_ADDR. Otherwise PC holds. PC is already pointing at the next byte.
  - HALT_REQ=1: state <= HALT. Otherwise state <= FETCH.
  - LOAD_PC and HALT_REQ together: the load is applied and the block halts. PC shows LOAD_ADDR in HALT.
- HALT:
  - PC and state frozen. HALTED=1. FETCH_EN=EXEC_EN=0.
  - Leaves HALT only on RESET. LOAD_PC and HALT_REQ are ignored.
- LOAD_ADDR is taken as-is, 12 bits, with no range check.

## Timing
- Every instruction takes 2 enabled cycles: FETCH, then EXECUTE.
- PC changes at the end of FETCH, so it is stable through EXECUTE. Decode reads the operand and the LOAD_ADDR source without hazard.
- Branch latency is 1 cycle: a load in EXECUTE cycle n makes ROM[LOAD_ADDR] the fetch in cycle n+1.
- Registered outputs change only on the CLK rising edge. FETCH_EN and EXEC_EN follow EN combinationally within the cycle.
- RESET mid-instruction, in either phase: next cycle is FETCH at RESET_PC. A pending LOAD_PC or HALT_REQ in that cycle is discarded.
- EN deassertion between FETCH and EXECUTE: EXECUTE is entered when EN returns. The instruction is not lost.

## Test plan
- Reset then EN=1 for 8 cycles, no loads:
  - PC sequence 000,001,001,002,002,003,003,004.
  - PHASE alternates 0,1 starting at 0.
  - FETCH_EN is high on even cycles.
- Wrap: force PC to 12'hFFE via a load, run 4 cycles. PC goes FFE -> FFF -> 000 with no glitch.
- Branch: in EXECUTE with PC=005, drive LOAD_PC=1, LOAD_ADDR=12'h3A0.
  - Next cycle: PC=3A0, PHASE=0, FETCH_EN=1.
  - LOAD_PC=1 during FETCH: PC only increments.
- Halt: HALT_REQ=1 together with LOAD_PC=1, LOAD_ADDR=12'h010, in EXECUTE.
  - Result: HALTED=1, PC=010, FETCH_EN=EXEC_EN=0.
  - Holds for 20 cycles, ignoring further requests. RESET returns PC=000, HALTED=0.
- EN gating: drop EN for 3 cycles inside EXECUTE. PC, PHASE and state hold, and both enables stay 0. Resume completes EXECUTE.
- Reset mid-operation: assert RESET during EXECUTE while LOAD_PC=1. Next cycle PC=000, PHASE=0, and the load is discarded.

Source files
------------

// File: rtl/pc_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_phase_sequencer
//  Purpose  : Front-end sequencer for the 4-bit processor. Holds the 12-bit
//             program counter into the 4096 x 8 program ROM, runs the
//             two-phase FETCH/EXECUTE toggle that paces the fetch register,
//             and applies branch loads and halt requests from decode.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_phase_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic        LOAD_PC,
  input  logic [11:0] LOAD_ADDR,
  input  logic        HALT_REQ,
  output logic [11:0] PC,
  output logic        PHASE,
  output logic        FETCH_EN,
  output logic        EXEC_EN,
  output logic        HALTED
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [11:0] pc;
  logic [11:0] next_pc;

  // State and program-counter registers; reset wins over EN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  // Next-state / next-PC decode. Everything holds unless EN is high.
  // The PC advances at the end of FETCH so it is stable through EXECUTE,
  // where decode may overwrite it with a branch target.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    if (EN) begin
      case (state)
        S_FETCH: begin
          // Natural 12-bit wrap from FFF to 000.
          next_pc    = pc + 12'd1;
          next_state = S_EXECUTE;
        end
        S_EXECUTE: begin
          // A load together with a halt still lands, so HALT shows the target.
          if (LOAD_PC) begin
            next_pc = LOAD_ADDR;
          end
          next_state = HALT_REQ ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          // Only RESET leaves HALT.
          next_state = S_HALT;
        end
        default: begin
          next_state = S_FETCH;
        end
      endcase
    end
  end

  // Output decode: registered-state flags plus EN-qualified phase strobes.
  always_comb begin
    PC       = pc;
    PHASE    = (state == S_EXECUTE);
    HALTED   = (state == S_HALT);
    FETCH_EN = EN && (state == S_FETCH);
    EXEC_EN  = EN && (state == S_EXECUTE);
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_phase_sequencer
//  Purpose  : Self-checking bench for pc_phase_sequencer using a directed
//             vector table plus hand-written halt-hold and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_phase_sequencer;

  logic        clk;
  logic        reset;
  logic        en;
  logic        load_pc;
  logic [11:0] load_addr;
  logic        halt_req;
  logic [11:0] pc;
  logic        phase;
  logic        fetch_en;
  logic        exec_en;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_phase_sequencer #(.RESET_PC(12'h000)) dut (
    .CLK       (clk),
    .RESET     (reset),
    .EN        (en),
    .LOAD_PC   (load_pc),
    .LOAD_ADDR (load_addr),
    .HALT_REQ  (halt_req),
    .PC        (pc),
    .PHASE     (phase),
    .FETCH_EN  (fetch_en),
    .EXEC_EN   (exec_en),
    .HALTED    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        ld;
    logic [11:0] addr;
    logic        hlt;
    logic [11:0] pc;
    logic        ph;
    logic        fe;
    logic        ee;
    logic        hl;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic chk_all(input int idx, input logic [11:0] e_pc, input logic e_ph,
                         input logic e_fe, input logic e_ee, input logic e_hl);
    chk("pc",       idx, pc,               e_pc);
    chk("phase",    idx, {11'd0, phase},    {11'd0, e_ph});
    chk("fetch_en", idx, {11'd0, fetch_en}, {11'd0, e_fe});
    chk("exec_en",  idx, {11'd0, exec_en},  {11'd0, e_ee});
    chk("halted",   idx, {11'd0, halted},   {11'd0, e_hl});
  endtask

  // Drive inputs mid-cycle, then compare outputs before the next rising edge.
  task automatic drive(input logic r, input logic e, input logic l, input logic [11:0] a, input logic h);
    @(negedge clk);
    reset = r; en = e; load_pc = l; load_addr = a; halt_req = h;
    #1;
  endtask

  initial begin
    //            rst  en   ld   addr    hlt   pc      ph   fe   ee   hl
    vecs[0]  = '{1'b0,1'b0,1'b0,12'h000,1'b0, 12'h000,1'b0,1'b0,1'b0,1'b0}; // reset state, EN low
    vecs[1]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h000,1'b0,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h001,1'b1,1'b0,1'b1,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h001,1'b0,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h002,1'b1,1'b0,1'b1,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h002,1'b0,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h003,1'b1,1'b0,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h003,1'b0,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h004,1'b1,1'b0,1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b1,12'hFFE,1'b1, 12'h004,1'b0,1'b1,1'b0,1'b0}; // load/halt in FETCH ignored
    vecs[10] = '{1'b0,1'b1,1'b1,12'h3A0,1'b0, 12'h005,1'b1,1'b0,1'b1,1'b0}; // branch to 3A0
    vecs[11] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h3A0,1'b0,1'b1,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b1,12'hFFE,1'b0, 12'h3A1,1'b1,1'b0,1'b1,1'b0}; // branch to FFE
    vecs[13] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'hFFE,1'b0,1'b1,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'hFFF,1'b1,1'b0,1'b1,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'hFFF,1'b0,1'b1,1'b0,1'b0};
    vecs[16] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h000,1'b1,1'b0,1'b1,1'b0}; // wrapped
    vecs[17] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h000,1'b0,1'b1,1'b0,1'b0};
    vecs[18] = '{1'b0,1'b0,1'b1,12'h555,1'b1, 12'h001,1'b1,1'b0,1'b0,1'b0}; // EN low inside EXECUTE
    vecs[19] = '{1'b0,1'b0,1'b1,12'h555,1'b1, 12'h001,1'b1,1'b0,1'b0,1'b0};
    vecs[20] = '{1'b0,1'b0,1'b0,12'h000,1'b0, 12'h001,1'b1,1'b0,1'b0,1'b0};
    vecs[21] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h001,1'b1,1'b0,1'b1,1'b0}; // resume EXECUTE
    vecs[22] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h001,1'b0,1'b1,1'b0,1'b0};
    vecs[23] = '{1'b1,1'b1,1'b1,12'h777,1'b1, 12'h002,1'b1,1'b0,1'b1,1'b0}; // reset during EXECUTE with load
    vecs[24] = '{1'b0,1'b1,1'b0,12'h000,1'b0, 12'h000,1'b0,1'b1,1'b0,1'b0}; // load discarded
    vecs[25] = '{1'b0,1'b1,1'b1,12'h010,1'b1, 12'h001,1'b1,1'b0,1'b1,1'b0}; // load + halt
    vecs[26] = '{1'b0,1'b1,1'b1,12'h222,1'b1, 12'h010,1'b0,1'b0,1'b0,1'b1}; // halted at 010

    reset = 1'b1; en = 1'b1; load_pc = 1'b0; load_addr = 12'h000; halt_req = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 12'h9AB, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].addr, vecs[i].hlt);
      chk_all(i, vecs[i].pc, vecs[i].ph, vecs[i].fe, vecs[i].ee, vecs[i].hl);
    end

    // HALT holds for 20 cycles regardless of requests and EN.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      chk_all(100 + k, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Reset releases HALT.
    drive(1'b1, 1'b1, 1'b1, 12'h123, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    chk_all(200, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Enables follow EN combinationally within a cycle (no clock edge between).
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);   // EXECUTE at 001
    chk_all(201, 12'h001, 1'b1, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    #1;
    chk_all(202, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    #1;
    chk_all(203, 12'h001, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset during FETCH returns to FETCH at the reset PC.
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);   // FETCH at 001
    chk_all(204, 12'h001, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 12'hABC, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    chk_all(205, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
